// File: rtl/rnd_sat_17_16_pkg.sv
// rtl/rnd_sat_17_16_pkg.sv - shared constants for the rnd_sat_17_16 output-conditioning stage
//
// Purpose: sample widths shared with the upstream adder stages, the
// saturation ceiling, and the rounding-constant helper used by the top.
// Ports: none (package).
package rnd_sat_17_16_pkg;

  localparam int SAMPLE_IN_W   = 17;
  localparam int SAMPLE_OUT_W  = 16;
  localparam int SHIFT_DEFAULT = 1;

  localparam logic [SAMPLE_OUT_W-1:0] OUT_MAX = '1;

  // Half-LSB of the shifted result; zero when no shift is applied so that
  // rounding degenerates to a pass-through.
  function automatic logic [31:0] rnd_const(input int shift);
    return (shift > 0) ? (32'd1 << (shift - 1)) : 32'd0;
  endfunction

  localparam logic [31:0] RND_CONST = rnd_const(SHIFT_DEFAULT);

endpackage

// File: rtl/rnd_sat_pipe_reg.sv
// rtl/rnd_sat_pipe_reg.sv - one valid/data register slice of the rnd_sat pipeline
//
// Purpose: holds one sample and its valid bit; loads both when en_i is high,
// otherwise holds. The enable is computed by the owner (bubble-collapsing).
// Ports:
//   clk, aresetn      clock, asynchronous active-low reset
//   en_i              load enable for this slice
//   valid_i, data_i   next valid bit and payload
//   valid_o, data_o   registered valid bit and payload
module rnd_sat_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rnd_sat_17_16.sv
// rtl/rnd_sat_17_16.sv - round half-up, shift right and saturate a 17-bit sum to 16 bits
//
// Purpose: two-stage pipelined output conditioner with valid/ready on both
// sides. Stage 1 adds the rounding constant, stage 2 shifts and saturates.
// Optional feature macro: RND_SAT_STATS_EN (saturation event counter).
// Ports:
//   clk, aresetn                    clock, asynchronous active-low reset
//   s_valid_i, s_ready_o, s_data_i  input sample handshake and data
//   m_valid_o, m_ready_i, m_data_o  output sample handshake and data
//   sat_o                           output sample was saturated
//   sat_cnt_o                       consumed saturated samples (0 unless macro set)
module rnd_sat_17_16
  import rnd_sat_17_16_pkg::*;
#(
  parameter int IN_WIDTH  = SAMPLE_IN_W,
  parameter int OUT_WIDTH = SAMPLE_OUT_W,
  parameter int SHIFT     = SHIFT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [IN_WIDTH-1:0]  s_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 sat_o,
  output logic [15:0]          sat_cnt_o
);

  localparam logic [IN_WIDTH:0] RND_ADD = (IN_WIDTH + 1)'(rnd_const(SHIFT));

  logic en1, en2;
  logic v1, v2;
  logic [IN_WIDTH:0]  r1_d, r1_q;
  logic [IN_WIDTH:0]  q;
  logic               sat_d;
  logic [OUT_WIDTH:0] s2_d, s2_q;

  // A stage may load when it is empty or its content moves on this edge,
  // so bubbles are squeezed out even while the output is stalled.
  assign en2       = !v2 || m_ready_i;
  assign en1       = !v1 || en2;
  assign s_ready_o = en1;

  // One extra bit keeps the rounding add from overflowing.
  assign r1_d = {1'b0, s_data_i} + RND_ADD;

  rnd_sat_pipe_reg #(.W(IN_WIDTH + 1)) u_stage1 (
    .clk     (clk),
    .aresetn (aresetn),
    .en_i    (en1),
    .valid_i (s_valid_i),
    .data_i  (r1_d),
    .valid_o (v1),
    .data_o  (r1_q)
  );

  // Any set bit at or above OUT_WIDTH means q exceeds the 16-bit ceiling.
  always_comb begin
    q     = r1_q >> SHIFT;
    sat_d = |q[IN_WIDTH:OUT_WIDTH];
    s2_d  = sat_d ? {1'b1, {OUT_WIDTH{1'b1}}} : {1'b0, q[OUT_WIDTH-1:0]};
  end

  rnd_sat_pipe_reg #(.W(OUT_WIDTH + 1)) u_stage2 (
    .clk     (clk),
    .aresetn (aresetn),
    .en_i    (en2),
    .valid_i (v1),
    .data_i  (s2_d),
    .valid_o (v2),
    .data_o  (s2_q)
  );

  assign m_valid_o = v2;
  assign sat_o     = s2_q[OUT_WIDTH];
  assign m_data_o  = s2_q[OUT_WIDTH-1:0];

`ifdef RND_SAT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts consumed saturated outputs; sticks at all-ones instead of wrapping.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (m_valid_o && m_ready_i && sat_o && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`else
  assign sat_cnt_o = '0;
`endif

endmodule

// File: doc/rnd_sat_17_16.md
Name: rnd_sat_17_16

Overview:
- Output-conditioning stage placed directly downstream of the 17-bit pipelined adder (add_16_16_l2) in the M2 channelizer datapath.
- Accepts the unsigned 17-bit sum, rounds half-up while shifting right by SHIFT, and saturates to 16 bits.
- Fully pipelined over 2 register stages with a valid/ready handshake on both sides.
- Pipeline stalls cleanly under downstream backpressure, with no data loss.

Parameters:
IN_WIDTH, 17, input sample width (unsigned)
OUT_WIDTH, 16, output sample width (unsigned)
SHIFT, 1, right-shift applied after rounding; legal range 0..IN_WIDTH-1

Ports:
clk  input  1  clock; all registers on rising edge
aresetn  input  1  asynchronous active-low reset
s_valid_i  input  1  input sample valid
s_ready_o  output  1  block can accept input this cycle
s_data_i  input  IN_WIDTH  unsigned sum from upstream adder
m_valid_o  output  1  output sample valid
m_ready_i  input  1  downstream accepts output
m_data_o  output  OUT_WIDTH  rounded/saturated sample
sat_o  output  1  high with m_valid_o when the current output was saturated
sat_cnt_o  output  16  saturation event count (optional feature)

Behaviour:
- Reset: one clock, asynchronous active-low reset on aresetn, as already decided.
  - Asserting aresetn low immediately clears v1, v2, all data registers, sat_o, m_data_o and sat_cnt_o to 0.
  - Reset mid-flight discards in-pipe samples.
  - First valid output after deassertion comes from a sample accepted after deassertion.
- Stage enables (bubble-collapsing):
  - en2 = !v2 | m_ready_i
  - en1 = !v1 | en2
  - s_ready_o = en1 (combinational)
- Transfers:
  - Input accepted when s_valid_i & s_ready_o.
  - Output consumed when m_valid_o & m_ready_i.
  - m_valid_o = v2.
- Stage 1 (when en1):
  - v1 <= s_valid_i.
  - r1 <= zero-extended s_data_i + (SHIFT>0 ? 2^(SHIFT-1) : 0), width IN_WIDTH+1 (no internal overflow).
- Stage 2 (when en2):
  - v2 <= v1.
  - q = r1 >> SHIFT.
  - If q > 2^OUT_WIDTH-1: m_data_o <= all ones and sat_o <= 1; else m_data_o <= q[OUT_WIDTH-1:0] and sat_o <= 0.
- Latency: exactly 2 clk from input acceptance to m_valid_o when m_ready_i is held high.
- Throughput: 1 sample/clk.
- Hold rules:
  - While m_valid_o & !m_ready_i, m_data_o and sat_o hold stable.
  - v1 holds if stage 2 is stalled and full.
- Boundary conditions:
  - Rounding is half-up: exact .5 rounds toward +inf.
  - SHIFT=0 makes rounding a no-op.
  - A bubble in v1 or v2 is filled even while the output is stalled.
  - Simultaneous output consume and input accept in the same cycle: no loss, order preserved.
- No combinational path from s_data_i to m_data_o.

Optional Feature:
- Macro RND_SAT_STATS_EN defined:
  - sat_cnt_o increments by 1 on each consumed output with sat_o=1.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared only by aresetn.
- Macro undefined: sat_cnt_o tied to 0 and no counter logic is built; sat_o remains functional either way.

Decomposition:
- Shared package holds:
  - localparam RND_CONST(SHIFT)
  - OUT_MAX = 2^OUT_WIDTH-1
  - sample width constants shared with adder stages (IN_WIDTH=17, OUT_WIDTH=16)
- One natural sub-module, rnd_sat_pipe_reg: a single valid/data register slice with enable/stall logic, instantiated twice.
- Stats counter stays inline under the macro.

Test Plan:
- SHIFT=1, m_ready_i=1, inputs 4, 5, 6, 131070 on consecutive cycles -> outputs 2, 3, 3, 65535 two cycles later, sat_o=0 throughout, one per clk.
- SHIFT=0, inputs 65535, 65536, 131071 -> outputs 65535 (sat_o=0), 65535 (sat_o=1), 65535 (sat_o=1); with RND_SAT_STATS_EN, sat_cnt_o=2 after consumption.
- Backpressure, SHIFT=1: 4 back-to-back inputs 10, 20, 30, 40 with m_ready_i low for cycles 2-5 -> s_ready_o drops once both stages are full; outputs 5, 10, 15, 20 delivered in order; m_data_o stable while stalled; nothing lost or duplicated.
- Bubble collapse: stage 1 holding a sample, stage 2 empty, m_ready_i=0 -> next edge moves the sample to stage 2 and s_ready_o stays 1.
- Reset mid-flight: aresetn low for 1 cycle with v1=v2=1 -> m_valid_o=0, m_data_o=0 and sat_cnt_o=0 immediately (asynchronous); the next accepted input 8 (SHIFT=1) emerges as 4 after 2 clk.
- Counter limit (RND_SAT_STATS_EN): 65537 saturating samples at SHIFT=0 -> sat_cnt_o stops at 16'hFFFF; macro undefined -> sat_cnt_o always 0.
